// File: rtl/spi_reg_burst_cntrl.sv
// spi_reg_burst_cntrl: mode-0 SPI burst register controller (clk/rst, start/write/address/burst_len/wdata/SPI_MISO in; busy/done/SPI_SCLK/SPI_MOSI/SPI_CS/rdata out)
module spi_reg_burst_cntrl #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int SCLK_FREQUENCY = 500_000,
  parameter int MAX_BURST = 4,
  parameter logic [7:0] WRITE_CMD = 8'h0A,
  parameter logic [7:0] READ_CMD = 8'h0B
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic write,
  input  logic [7:0] address,
  input  logic [$clog2(MAX_BURST):0] burst_len,
  input  logic [8*MAX_BURST-1:0] wdata,
  input  logic SPI_MISO,
  output logic busy,
  output logic done,
  output logic SPI_SCLK,
  output logic SPI_MOSI,
  output logic SPI_CS,
  output logic [8*MAX_BURST-1:0] rdata
);
  localparam int HALF = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
  localparam int HW = $clog2(HALF);
  localparam int BW = $clog2(MAX_BURST + 2);
  localparam int BLW = $clog2(MAX_BURST) + 1;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP} state_t;
  state_t state;
  logic [HW-1:0] hcnt;
  logic ph, wr_q, wrap;
  logic [2:0] bit_cnt;
  logic [BW-1:0] byte_cnt, last_q, di;
  logic [7:0] addr_q, rx, cur_byte, nxt_byte;
  logic [8*MAX_BURST-1:0] wdata_q;
  logic [BLW-1:0] eff_len;
  function automatic logic [7:0] frame_byte(input logic [BW-1:0] i, input logic w,
                                            input logic [7:0] a, input logic [8*MAX_BURST-1:0] wd);
    logic [BW-1:0] k;
    k = i - BW'(2);
    return i == '0 ? (w ? WRITE_CMD : READ_CMD) : i == BW'(1) ? a : w ? wd[8*k +: 8] : 8'h00;
  endfunction
  always_comb begin
    wrap = hcnt == HW'(HALF - 1);
    eff_len = burst_len == '0 ? BLW'(1) : burst_len > BLW'(MAX_BURST) ? BLW'(MAX_BURST) : burst_len;
    cur_byte = frame_byte(byte_cnt, wr_q, addr_q, wdata_q);
    nxt_byte = frame_byte(byte_cnt + BW'(1), wr_q, addr_q, wdata_q);
    di = byte_cnt - BW'(2);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      hcnt <= '0;
      ph <= 1'b0;
      bit_cnt <= 3'd7;
      byte_cnt <= '0;
      last_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rx <= '0;
      SPI_CS <= 1'b1;
      SPI_SCLK <= 1'b0;
      SPI_MOSI <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rdata <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) hcnt <= wrap ? '0 : hcnt + HW'(1);
      case (state)
        IDLE: if (start) begin
          state <= CS_SETUP;
          wr_q <= write;
          addr_q <= address;
          wdata_q <= wdata;
          last_q <= BW'(eff_len) + BW'(1);
          hcnt <= '0;
          ph <= 1'b0;
          bit_cnt <= 3'd7;
          byte_cnt <= '0;
          busy <= 1'b1;
          SPI_CS <= 1'b0;
          SPI_MOSI <= write ? WRITE_CMD[7] : READ_CMD[7];
        end
        CS_SETUP: if (wrap) state <= SHIFT;
        SHIFT: if (wrap && !ph) begin
          SPI_SCLK <= 1'b1;
          ph <= 1'b1;
          rx <= {rx[6:0], SPI_MISO};
          if (!wr_q && bit_cnt == 3'd0 && byte_cnt >= BW'(2)) rdata[8*di +: 8] <= {rx[6:0], SPI_MISO};
        end else if (wrap) begin
          SPI_SCLK <= 1'b0;
          ph <= 1'b0;
          if (bit_cnt != 3'd0) begin
            bit_cnt <= bit_cnt - 3'd1;
            SPI_MOSI <= cur_byte[bit_cnt - 3'd1];
          end else if (byte_cnt == last_q) begin
            state <= CS_HOLD;
            SPI_MOSI <= 1'b0;
          end else begin
            byte_cnt <= byte_cnt + BW'(1);
            bit_cnt <= 3'd7;
            SPI_MOSI <= nxt_byte[7];
          end
        end
        CS_HOLD: if (wrap) begin
          SPI_CS <= 1'b1;
          state <= CS_GAP;
        end
        CS_GAP: if (wrap) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_reg_burst_cntrl.sv
// tb_spi_reg_burst_cntrl: directed self-checking bench with SPI slave model and frame monitor
module tb_spi_reg_burst_cntrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, write = 1'b0;
  logic [7:0] address = '0;
  logic [2:0] burst_len = '0;
  logic [31:0] wdata = '0;
  logic SPI_MISO;
  logic busy, done, SPI_SCLK, SPI_MOSI, SPI_CS;
  logic [31:0] rdata;
  logic [63:0] sl_bits = '0;
  int rises = 0, fr_rise = 0, bitn = 0, dones = 0, frames = 0, cs_low = 0, gap = 0, sclk_bad = 0;
  int passed = 0, total = 0, fails = 0;
  longint t_fall = 0, t_rise = 0;
  bit in_frame = 0;
  logic [7:0] cur = '0;
  logic [7:0] mq[$];
  spi_reg_burst_cntrl dut (
    .clk(clk), .rst(rst), .start(start), .write(write), .address(address),
    .burst_len(burst_len), .wdata(wdata), .SPI_MISO(SPI_MISO), .busy(busy), .done(done),
    .SPI_SCLK(SPI_SCLK), .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS), .rdata(rdata)
  );
  assign SPI_MISO = fr_rise < 64 ? sl_bits[63 - fr_rise] : 1'b0;
  always #5 clk = ~clk;
  always @(posedge SPI_SCLK) begin
    if (SPI_CS !== 1'b0) sclk_bad++;
    rises++;
    fr_rise++;
    cur = {cur[6:0], SPI_MOSI};
    bitn++;
    if (bitn == 8) begin
      mq.push_back(cur);
      bitn = 0;
    end
  end
  always @(negedge SPI_CS) begin
    t_fall = $time;
    fr_rise = 0;
    in_frame = 1;
    if (t_rise != 0) gap = int'((t_fall - t_rise) / 10);
  end
  always @(posedge SPI_CS) if (in_frame) begin
    t_rise = $time;
    cs_low = int'((t_rise - t_fall) / 10);
    frames++;
    in_frame = 0;
  end
  always @(posedge clk) if (done === 1'b1) dones++;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] pack();
    logic [63:0] v = '0;
    foreach (mq[i]) v = {v[55:0], mq[i]};
    return v;
  endfunction
  task automatic clear_mon();
    rises = 0; bitn = 0; dones = 0; frames = 0; cs_low = 0; gap = 0; sclk_bad = 0; t_rise = 0;
    mq.delete();
  endtask
  task automatic launch(input logic w, input logic [7:0] a, input logic [2:0] l, input logic [31:0] wd);
    @(negedge clk);
    write = w; address = a; burst_len = l; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cs", 64'(SPI_CS), 64'd1);
    chk("rst_sclk", 64'(SPI_SCLK), 64'd0);
    chk("rst_mosi", 64'(SPI_MOSI), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    clear_mon();
    launch(1'b1, 8'h2D, 3'd1, 32'hDDCCBB02);
    chk("w1_busy", 64'(busy), 64'd1);
    wait_done("w1_done_seen");
    @(negedge clk);
    chk("w1_done_pulse", 64'(done), 64'd0);
    chk("w1_busy_end", 64'(busy), 64'd0);
    chk("w1_mosi", pack(), 64'h0A2D02);
    chk("w1_nbytes", 64'(mq.size()), 64'd3);
    chk("w1_rises", 64'(rises), 64'd24);
    chk("w1_cs_low", 64'(cs_low), 64'd5000);
    chk("w1_dones", 64'(dones), 64'd1);
    chk("w1_rdata", 64'(rdata), 64'd0);
    chk("w1_sclk_cs", 64'(sclk_bad), 64'd0);
    clear_mon();
    sl_bits = {8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 16'h0};
    launch(1'b0, 8'h20, 3'd7, 32'h0);
    wait_done("r7_done_seen");
    @(negedge clk);
    chk("r7_mosi", pack(), 64'h0B20_0000_0000);
    chk("r7_nbytes", 64'(mq.size()), 64'd6);
    chk("r7_rises", 64'(rises), 64'd48);
    chk("r7_cs_low", 64'(cs_low), 64'd9800);
    chk("r7_rdata", 64'(rdata), 64'h44332211);
    clear_mon();
    sl_bits = {8'hFF, 8'hFF, 8'h5A, 8'hA5, 32'h0};
    launch(1'b0, 8'h0E, 3'd2, 32'h0);
    wait_done("r2_done_seen");
    @(negedge clk);
    chk("r2_mosi", pack(), 64'h0B0E0000);
    chk("r2_nbytes", 64'(mq.size()), 64'd4);
    chk("r2_rises", 64'(rises), 64'd32);
    chk("r2_cs_low", 64'(cs_low), 64'd6600);
    chk("r2_rdata", 64'(rdata), 64'h4433A55A);
    clear_mon();
    launch(1'b1, 8'h1F, 3'd0, 32'hAAAAAA77);
    wait_done("w0_done_seen");
    @(negedge clk);
    chk("w0_mosi", pack(), 64'h0A1F77);
    chk("w0_rises", 64'(rises), 64'd24);
    chk("w0_rdata", 64'(rdata), 64'h4433A55A);
    clear_mon();
    launch(1'b1, 8'h05, 3'd1, 32'h33);
    repeat (2000) @(negedge clk);
    start = 1'b1; write = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done("mid_done_seen");
    repeat (400) @(negedge clk);
    chk("mid_frames", 64'(frames), 64'd1);
    chk("mid_dones", 64'(dones), 64'd1);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_cs", 64'(SPI_CS), 64'd1);
    chk("mid_mosi", pack(), 64'h0A0533);
    clear_mon();
    launch(1'b1, 8'h33, 3'd2, 32'h0000BEEF);
    begin
      bit hit = 0;
      for (int i = 0; i < 20000 && !hit; i++) begin
        @(negedge clk);
        hit = rises >= 12;
      end
      chk("abort_reached_addr", 64'(hit), 64'd1);
    end
    rst = 1'b1;
    #1;
    chk("abort_cs", 64'(SPI_CS), 64'd1);
    chk("abort_sclk", 64'(SPI_SCLK), 64'd0);
    chk("abort_mosi", 64'(SPI_MOSI), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_no_done", 64'(dones), 64'd0);
    clear_mon();
    sl_bits = {8'hFF, 8'hFF, 8'hC3, 40'h0};
    launch(1'b0, 8'h44, 3'd1, 32'h0);
    wait_done("post_done_seen");
    @(negedge clk);
    chk("post_mosi", pack(), 64'h0B4400);
    chk("post_rdata", 64'(rdata), 64'h000000C3);
    chk("post_cs_low", 64'(cs_low), 64'd5000);
    clear_mon();
    @(negedge clk);
    write = 1'b1; address = 8'h10; burst_len = 3'd1; wdata = 32'h55; start = 1'b1;
    wait_done("b2b_first_done");
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept", 64'(busy), 64'd1);
    wait_done("b2b_second_done");
    repeat (5) @(negedge clk);
    chk("b2b_dones", 64'(dones), 64'd2);
    chk("b2b_frames", 64'(frames), 64'd2);
    chk("b2b_gap", 64'(gap), 64'd101);
    chk("b2b_mosi", pack(), 64'h0A10550A1055);
    chk("b2b_rises", 64'(rises), 64'd48);
    chk("b2b_sclk_cs", 64'(sclk_bad), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
